// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package mips_pkg;

   localparam int unsigned HDR_BYTES      = 2;
   localparam int unsigned CSUM_BYTES     = 1;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned BYTE_IDX_W     = 2;
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned CNT_W          = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_CSUM   = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERR    = 3'd6
   } loader_state_e;

   // One imem write transaction
   typedef struct packed {
      logic [WORD_W-1:0] addr;
      logic [WORD_W-1:0] data;
   } imem_wr_t;

   // Total stream length in bytes for a program of n_words words
   function automatic int unsigned stream_bytes(input int unsigned n_words);
      return HDR_BYTES + n_words * BYTES_PER_WORD + CSUM_BYTES;
   endfunction

   // Byte address of word idx relative to base
   function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                   input logic [CNT_W-1:0]  idx);
      return base + {14'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs four little-endian bytes into a 32-bit word; the word is presented
// combinationally alongside the fourth byte so the caller can register it.
module word_assembler
   import mips_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_in,
   input  logic [BYTE_IDX_W-1:0] byte_idx,
   output logic [WORD_W-1:0]     word_out_c,
   output logic                  word_done_c
);

   logic [23:0] lo_q, lo_d;

   // Capture bytes 0..2 in their lane; byte 3 is taken straight from the input
   always_comb begin
      lo_d = lo_q;
      if (byte_valid) begin
         case (byte_idx)
            2'd0:    lo_d[7:0]   = byte_in;
            2'd1:    lo_d[15:8]  = byte_in;
            2'd2:    lo_d[23:16] = byte_in;
            default: lo_d        = lo_q;
         endcase
      end
   end

   // Lane storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lo_q <= 24'd0;
      else        lo_q <= lo_d;
   end

   assign word_out_c  = {byte_in, lo_q};
   assign word_done_c = byte_valid && (byte_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Serial boot loader: receives a length-prefixed, XOR-checksummed program
// image, writes it into instruction memory and releases the CPU reset only
// after the checksum has been verified.
module imem_loader
   import mips_pkg::*;
#(
   parameter int unsigned MAX_WORDS = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_rst_n,
   output logic        done,
   output logic        err,
   output logic [15:0] words_loaded
);

   loader_state_e         state_q, state_d;
   logic                  rx_ready_q, rx_ready_d;
   logic [7:0]            len_lo_q, len_lo_d;
   logic [CNT_W-1:0]      len_q, len_d;
   logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
   logic [7:0]            csum_q, csum_d;
   logic [CNT_W-1:0]      words_loaded_q, words_loaded_d;
   imem_wr_t              wr_q, wr_d;
   logic                  imem_we_q, imem_we_d;
   logic                  cpu_rst_n_q, cpu_rst_n_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic                  accept_c;
   logic                  data_byte_c;
   logic [CNT_W-1:0]      len_full_c;
   logic [WORD_W-1:0]     word_c;
   logic                  word_done_c;

   assign accept_c    = rx_valid && rx_ready_q;
   assign data_byte_c = accept_c && (state_q == ST_DATA);
   assign len_full_c  = {rx_data, len_lo_q};

   word_assembler u_word_asm (
      .clk         (clk),
      .rst_n       (rst_n),
      .byte_valid  (data_byte_c),
      .byte_in     (rx_data),
      .byte_idx    (byte_idx_q),
      .word_out_c  (word_c),
      .word_done_c (word_done_c)
   );

   // Next-state, counters, checksum and registered-output computation
   always_comb begin
      state_d        = state_q;
      len_lo_d       = len_lo_q;
      len_d          = len_q;
      byte_idx_d     = byte_idx_q;
      csum_d         = csum_q;
      words_loaded_d = words_loaded_q;
      wr_d           = wr_q;
      imem_we_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            if (accept_c) begin
               len_lo_d = rx_data;
               state_d  = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (accept_c) begin
               len_d = len_full_c;
               if (32'(len_full_c) > MAX_WORDS) state_d = ST_ERR;
               else if (len_full_c == 16'd0)    state_d = ST_CSUM;
               else                             state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (accept_c) begin
               csum_d     = csum_q ^ rx_data;
               byte_idx_d = byte_idx_q + 2'd1;
               if (word_done_c) begin
                  imem_we_d      = 1'b1;
                  wr_d.addr      = word_addr(BASE_ADDR, words_loaded_q);
                  wr_d.data      = word_c;
                  words_loaded_d = words_loaded_q + 16'd1;
                  if ((words_loaded_q + 16'd1) == len_q) state_d = ST_CSUM;
               end
            end
         end
         ST_CSUM: begin
            if (accept_c) begin
               state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
            end
         end
         ST_DONE: state_d = ST_DONE;
         ST_ERR:  state_d = ST_ERR;
         default: state_d = ST_ERR;
      endcase

      rx_ready_d  = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) ||
                    (state_d == ST_DATA)   || (state_d == ST_CSUM);
      done_d      = (state_d == ST_DONE);
      err_d       = (state_d == ST_ERR);
      cpu_rst_n_d = (state_d == ST_DONE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         rx_ready_q     <= 1'b0;
         len_lo_q       <= 8'd0;
         len_q          <= 16'd0;
         byte_idx_q     <= 2'd0;
         csum_q         <= 8'd0;
         words_loaded_q <= 16'd0;
         wr_q           <= '{addr: BASE_ADDR, data: 32'd0};
         imem_we_q      <= 1'b0;
         cpu_rst_n_q    <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         rx_ready_q     <= rx_ready_d;
         len_lo_q       <= len_lo_d;
         len_q          <= len_d;
         byte_idx_q     <= byte_idx_d;
         csum_q         <= csum_d;
         words_loaded_q <= words_loaded_d;
         wr_q           <= wr_d;
         imem_we_q      <= imem_we_d;
         cpu_rst_n_q    <= cpu_rst_n_d;
         done_q         <= done_d;
         err_q          <= err_d;
      end
   end

   assign rx_ready     = rx_ready_q;
   assign imem_we      = imem_we_q;
   assign imem_addr    = wr_q.addr;
   assign imem_wdata   = wr_q.data;
   assign cpu_rst_n    = cpu_rst_n_q;
   assign done         = done_q;
   assign err          = err_q;
   assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level model.
module tb_imem_loader;
   import mips_pkg::*;

   localparam int unsigned MAX_W = 256;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_rst_n;
   logic        done;
   logic        err;
   logic [15:0] words_loaded;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   imem_loader #(.MAX_WORDS(MAX_W), .BASE_ADDR(BASE)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_rst_n    (cpu_rst_n),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " rx_ready"},     32'(rx_ready),     32'd0);
      chk({tag, " imem_we"},      32'(imem_we),      32'd0);
      chk({tag, " imem_addr"},    imem_addr,         BASE);
      chk({tag, " imem_wdata"},   imem_wdata,        32'd0);
      chk({tag, " cpu_rst_n"},    32'(cpu_rst_n),    32'd0);
      chk({tag, " done"},         32'(done),         32'd0);
      chk({tag, " err"},          32'(err),          32'd0);
      chk({tag, " words_loaded"}, 32'(words_loaded), 32'd0);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'd0;
      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready after reset", 32'(rx_ready), 32'd1);
   endtask

   // Drive a stream and check every cycle against the stream-level model.
   // gap_mode: 0 = always valid, 1 = toggle 1/0, 2 = random.
   // cut >= 0 stops after that many consumed bytes (partial load).
   task automatic run_case(input logic [7:0] s[$], input int gap_mode, input int cut);
      int unsigned n;
      bit          len_err;
      int          n_consume;
      logic [7:0]  xsum;
      bit          exp_done;
      int          idx;
      int          cycles;
      int          budget;
      int          w_exp;
      bit          word_end;
      bit          tog;
      bit          v;
      logic [31:0] exp_word;
      int          k;

      n         = {s[1], s[0]};
      len_err   = (n > MAX_W);
      n_consume = len_err ? 2 : int'(stream_bytes(n));
      if (cut >= 0) n_consume = cut;
      xsum = 8'd0;
      if (!len_err)
         for (int i = 0; i < int'(4 * n); i++) xsum ^= s[2 + i];
      exp_done = !len_err && (s[2 + 4 * n] == xsum);

      idx = 0; cycles = 0; w_exp = 0; word_end = 1'b0; tog = 1'b1;
      budget = 4 * n_consume + 50;
      while (idx < n_consume && cycles < budget) begin
         @(negedge clk);
         cycles++;
         chk("we strobe", 32'(imem_we), 32'(word_end));
         if (word_end) begin
            k = 2 + 4 * w_exp;
            exp_word = {s[k + 3], s[k + 2], s[k + 1], s[k]};
            chk("wr addr",  imem_addr,         BASE + 32'(4 * w_exp));
            chk("wr data",  imem_wdata,        exp_word);
            chk("wr count", 32'(words_loaded), 32'(w_exp + 1));
            w_exp++;
         end
         chk("done&err", 32'(done && err), 32'd0);
         word_end = 1'b0;
         case (gap_mode)
            0:       v = 1'b1;
            1:       begin v = tog; tog = ~tog; end
            default: v = 1'($urandom_range(0, 1));
         endcase
         rx_valid = v;
         rx_data  = v ? s[idx] : 8'($urandom);
         if (v && rx_ready) begin
            word_end = !len_err && idx >= 2 && idx < int'(2 + 4 * n) && ((idx - 2) % 4 == 3);
            idx++;
         end
      end
      if (idx < n_consume) chk("stream timeout", 32'(idx), 32'(n_consume));

      @(negedge clk);
      rx_valid = 1'b0;
      chk("last we strobe", 32'(imem_we), 32'(word_end));
      if (word_end) begin
         k = 2 + 4 * w_exp;
         exp_word = {s[k + 3], s[k + 2], s[k + 1], s[k]};
         chk("last wr addr", imem_addr,  BASE + 32'(4 * w_exp));
         chk("last wr data", imem_wdata, exp_word);
         w_exp++;
      end
      if (cut >= 0) return;

      // Bytes offered after the end of the load must be ignored
      for (int i = 0; i < 4; i++) begin
         rx_valid = 1'b1;
         rx_data  = 8'($urandom);
         @(negedge clk);
         chk("post we",    32'(imem_we),  32'd0);
         chk("post ready", 32'(rx_ready), 32'd0);
      end
      rx_valid = 1'b0;
      chk("final done",      32'(done),         32'(exp_done));
      chk("final err",       32'(err),          32'(!exp_done));
      chk("final cpu_rst_n", 32'(cpu_rst_n),    32'(exp_done));
      chk("final words",     32'(words_loaded), len_err ? 32'd0 : 32'(n));
      chk("final writes",    32'(w_exp),        len_err ? 32'd0 : 32'(n));
   endtask

   task automatic build_random(output logic [7:0] s[$]);
      int unsigned n;
      logic [7:0]  x;
      logic [7:0]  b;
      s = {};
      n = ($urandom_range(0, 7) == 0) ? 257 + $urandom_range(0, 40) : $urandom_range(0, 6);
      s.push_back(8'(n));
      s.push_back(8'(n >> 8));
      if (n > MAX_W) return;
      x = 8'd0;
      for (int i = 0; i < int'(4 * n); i++) begin
         b = 8'($urandom);
         x ^= b;
         s.push_back(b);
      end
      if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
      s.push_back(x);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] s[$];
      logic [7:0] x;

      rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
      #1;
      chk_reset_vals("async reset");

      // Single word, good checksum (0x78^0x56^0x34^0x12 = 0x08)
      do_reset();
      s = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
      run_case(s, 0, -1);

      // Two words, bad checksum
      do_reset();
      s = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
      run_case(s, 0, -1);

      // Empty program
      do_reset();
      s = '{8'h00, 8'h00, 8'h00};
      run_case(s, 0, -1);

      // Length over the limit
      do_reset();
      s = '{8'h01, 8'h01};
      run_case(s, 0, -1);

      // Throttled source on the single-word stream
      do_reset();
      s = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
      run_case(s, 1, -1);

      // Reset after two data bytes, then a fresh load
      do_reset();
      run_case(s, 0, 4);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("mid-load reset");
      do_reset();
      run_case(s, 2, -1);

      // Maximum length program
      do_reset();
      s = {8'h00, 8'h01};
      x = 8'd0;
      for (int i = 0; i < 4 * 256; i++) begin
         s.push_back(8'($urandom));
         x ^= s[s.size() - 1];
      end
      s.push_back(x);
      run_case(s, 0, -1);

      // Randomized streams
      for (int t = 0; t < 25; t++) begin
         do_reset();
         build_random(s);
         run_case(s, $urandom_range(0, 2), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
